// File: rtl/div_unit_pkg.sv
// Shared widths, FSM encoding and handshake constants for the radix-2 divider.
package div_unit_pkg;

  localparam int RegBus       = 32;
  localparam int DoubleRegBus = 64;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  // Two's-complement negate when neg is set; 0x80000000 maps to itself (unsigned 2^31).
  function automatic logic [RegBus-1:0] negate_if(input logic [RegBus-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/div_unit_if.sv
// EX <-> divider handshake: operands and start/annul in, {remainder, quotient} and ready out.
interface div_unit_if;
  import div_unit_pkg::*;

  logic                    signed_div_i;
  logic [RegBus-1:0]       opdata1_i;
  logic [RegBus-1:0]       opdata2_i;
  logic                    start_i;
  logic                    annul_i;
  logic [DoubleRegBus-1:0] result_o;
  logic                    ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );

endinterface

// File: rtl/div_unit.sv
// Multi-cycle 32-bit restoring divider (DIV/DIVU), one quotient bit per cycle.
// Define DIV_SIGNED_EN to build the signed (DIV) path; otherwise every operation is unsigned.
module div_unit
  import div_unit_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  bus
);

  div_state_e              state, state_nxt;
  logic [5:0]              cnt, cnt_nxt;
  logic [DoubleRegBus:0]   dividend, dividend_nxt;
  logic [RegBus-1:0]       divisor, divisor_nxt;
  logic [DoubleRegBus-1:0] result, result_nxt;
  logic                    ready, ready_nxt;

  logic [RegBus:0]         diff;
  logic [RegBus-1:0]       mag_a, mag_b;
  logic [RegBus-1:0]       quot_fix, rem_fix;

  // Partial remainder sits in [63:32] with the next dividend bit already shifted into bit 32.
  assign diff = {1'b0, dividend[2*RegBus-1:RegBus]} - {1'b0, divisor};

`ifdef DIV_SIGNED_EN
  logic neg_a, neg_b, load, neg_quot, neg_rem;

  assign neg_a = bus.signed_div_i & bus.opdata1_i[RegBus-1];
  assign neg_b = bus.signed_div_i & bus.opdata2_i[RegBus-1];
  assign mag_a = negate_if(bus.opdata1_i, neg_a);
  assign mag_b = negate_if(bus.opdata2_i, neg_b);
  assign load  = (state == DivFree) && bus.start_i && !bus.annul_i && (bus.opdata2_i != '0);

  always_ff @(posedge clk) begin
    if (load) begin
      neg_quot <= neg_a ^ neg_b;
      neg_rem  <= neg_a;
    end
  end

  assign quot_fix = negate_if(dividend[RegBus-1:0], neg_quot);
  assign rem_fix  = negate_if(dividend[DoubleRegBus:RegBus+1], neg_rem);
`else
  logic unused_signed;

  assign unused_signed = bus.signed_div_i;
  assign mag_a         = bus.opdata1_i;
  assign mag_b         = bus.opdata2_i;
  assign quot_fix      = dividend[RegBus-1:0];
  assign rem_fix       = dividend[DoubleRegBus:RegBus+1];
`endif

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    dividend_nxt = dividend;
    divisor_nxt  = divisor;
    result_nxt   = result;
    ready_nxt    = ready;
    case (state)
      DivFree: begin
        ready_nxt  = DivResultNotReady;
        result_nxt = '0;
        if (bus.start_i == DivStart && !bus.annul_i) begin
          if (bus.opdata2_i == '0) begin
            state_nxt = DivByZero;
          end else begin
            divisor_nxt  = mag_b;
            dividend_nxt = {{RegBus{1'b0}}, mag_a, 1'b0};
            cnt_nxt      = 6'd0;
            state_nxt    = DivOn;
          end
        end
      end
      DivByZero: begin
        dividend_nxt = '0;
        result_nxt   = '0;
        ready_nxt    = DivResultReady;
        state_nxt    = DivEnd;
      end
      DivOn: begin
        if (bus.annul_i) begin
          state_nxt = DivFree;
        end else if (cnt != 6'd32) begin
          if (diff[RegBus]) begin
            dividend_nxt = {dividend[DoubleRegBus-1:0], 1'b0};
          end else begin
            dividend_nxt = {diff[RegBus-1:0], dividend[RegBus-1:0], 1'b1};
          end
          cnt_nxt = cnt + 6'd1;
        end else begin
          result_nxt = {rem_fix, quot_fix};
          ready_nxt  = DivResultReady;
          cnt_nxt    = 6'd0;
          state_nxt  = DivEnd;
        end
      end
      DivEnd: begin
        if (bus.start_i == DivStop) begin
          result_nxt = '0;
          ready_nxt  = DivResultNotReady;
          state_nxt  = DivFree;
        end
      end
      default: state_nxt = DivFree;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= DivFree;
      cnt    <= 6'd0;
      result <= '0;
      ready  <= DivResultNotReady;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      result <= result_nxt;
      ready  <= ready_nxt;
    end
  end

  // Iteration datapath needs no reset: it is always reloaded before it is read.
  always_ff @(posedge clk) begin
    dividend <= dividend_nxt;
    divisor  <= divisor_nxt;
  end

  assign bus.result_o = result;
  assign bus.ready_o  = ready;

  a_ready_only_in_end: assert property (@(posedge clk) disable iff (!rst)
    ready |-> state == DivEnd);
  a_result_zero_idle: assert property (@(posedge clk) disable iff (!rst)
    !ready |-> result == '0);
  a_cnt_bound: assert property (@(posedge clk) disable iff (!rst)
    cnt <= 6'd32);

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: latency, results, hold/clear, annul, reset.
module tb_div_unit;
  import div_unit_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;

  div_unit_if bus();

  div_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [63:0] exp;
  } vec_t;

  vec_t uv [6] = '{
    '{32'd100,        32'd7,          1'b0, 64'h00000002_0000000E},
    '{32'hFFFFFFFF,   32'hFFFFFFFF,   1'b0, 64'h00000000_00000001},
    '{32'd5,          32'd10,         1'b0, 64'h00000005_00000000},
    '{32'hDEADBEEF,   32'h00000010,   1'b0, 64'h0000000F_0DEADBEE},
    '{32'h80000000,   32'hFFFFFFFF,   1'b0, 64'h80000000_00000000},
    '{32'hFFFFFFF9,   32'd2,          1'b0, 64'h00000001_7FFFFFFC}
  };

`ifdef DIV_SIGNED_EN
  vec_t sv [5] = '{
    '{32'hFFFFFFF9, 32'd2,        1'b1, 64'hFFFFFFFF_FFFFFFFD},
    '{32'd7,        32'hFFFFFFFE, 1'b1, 64'h00000001_FFFFFFFD},
    '{32'hFFFFFFF8, 32'hFFFFFFFD, 1'b1, 64'hFFFFFFFE_00000002},
    '{32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h00000000_80000000},
    '{32'h80000000, 32'd2,        1'b1, 64'h00000000_C0000000}
  };
`else
  vec_t sv [5] = '{
    '{32'hFFFFFFF9, 32'd2,        1'b1, 64'h00000001_7FFFFFFC},
    '{32'd7,        32'hFFFFFFFE, 1'b1, 64'h00000007_00000000},
    '{32'hFFFFFFF8, 32'hFFFFFFFD, 1'b1, 64'hFFFFFFF8_00000000},
    '{32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h80000000_00000000},
    '{32'h80000000, 32'd2,        1'b1, 64'h00000000_40000000}
  };
`endif

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.signed_div_i = s;
    bus.start_i      = 1'b1;
  endtask

  task automatic end_op;
    bus.start_i = 1'b0;
    tick;
  endtask

  // Returns the number of edges after the first one taken here until ready_o is seen, -1 on timeout.
  task automatic wait_ready(output int edges);
    edges = -1;
    for (int i = 1; i <= 100; i++) begin
      tick;
      if (bus.ready_o === 1'b1) begin
        edges = i - 1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #2;
    vectors++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: ready=%b result=%h, expected ready=0 result=0", bus.ready_o, bus.result_o);
    end
    tick;
    tick;
    rst = 1'b1;
    tick;
    tick;
    vectors++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
      miscompares++;
      $display("FAIL idle_after_reset: ready=%b result=%h, expected ready=0 result=0", bus.ready_o, bus.result_o);
    end
  endtask

  task automatic test_unsigned;
    int edges;
    for (int k = 0; k < 6; k++) begin
      start_op(uv[k].a, uv[k].b, uv[k].s);
      wait_ready(edges);
      vectors++;
      if (edges !== 33) begin
        miscompares++;
        $display("FAIL unsigned_latency[%0d]: got %0d edges, expected 33", k, edges);
      end
      vectors++;
      if (bus.result_o !== uv[k].exp) begin
        miscompares++;
        $display("FAIL unsigned_result[%0d]: got %h, expected %h", k, bus.result_o, uv[k].exp);
      end
      // Operand churn and annul while DivEnd is held must not disturb the result.
      bus.opdata1_i = 32'h0;
      bus.opdata2_i = 32'h0;
      bus.annul_i   = 1'b1;
      tick;
      tick;
      vectors++;
      if (bus.ready_o !== 1'b1 || bus.result_o !== uv[k].exp) begin
        miscompares++;
        $display("FAIL unsigned_hold[%0d]: ready=%b result=%h, expected ready=1 result=%h",
                 k, bus.ready_o, bus.result_o, uv[k].exp);
      end
      bus.annul_i = 1'b0;
      end_op;
      vectors++;
      if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
        miscompares++;
        $display("FAIL unsigned_clear[%0d]: ready=%b result=%h, expected ready=0 result=0",
                 k, bus.ready_o, bus.result_o);
      end
    end
  endtask

  task automatic test_signed;
    int edges;
    for (int k = 0; k < 5; k++) begin
      start_op(sv[k].a, sv[k].b, sv[k].s);
      wait_ready(edges);
      vectors++;
      if (edges !== 33) begin
        miscompares++;
        $display("FAIL signed_latency[%0d]: got %0d edges, expected 33", k, edges);
      end
      vectors++;
      if (bus.result_o !== sv[k].exp) begin
        miscompares++;
        $display("FAIL signed_result[%0d]: got %h, expected %h", k, bus.result_o, sv[k].exp);
      end
      end_op;
    end
  endtask

  task automatic test_div_by_zero;
    int edges;
    start_op(32'h00001234, 32'h0, 1'b0);
    wait_ready(edges);
    vectors++;
    if (edges !== 1 || bus.result_o !== 64'd0) begin
      miscompares++;
      $display("FAIL div_zero_unsigned: edges=%0d result=%h, expected edges=1 result=0", edges, bus.result_o);
    end
    end_op;
    start_op(32'hFFFFFFF0, 32'h0, 1'b1);
    wait_ready(edges);
    vectors++;
    if (edges !== 1 || bus.result_o !== 64'd0) begin
      miscompares++;
      $display("FAIL div_zero_signed: edges=%0d result=%h, expected edges=1 result=0", edges, bus.result_o);
    end
    end_op;
  endtask

  task automatic test_annul;
    int edges;
    int ready_seen;
    start_op(32'd100, 32'd7, 1'b0);
    repeat (11) tick;
    bus.annul_i = 1'b1;
    tick;
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    ready_seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick;
      if (bus.ready_o !== 1'b0) ready_seen++;
    end
    vectors++;
    if (ready_seen !== 0) begin
      miscompares++;
      $display("FAIL annul_no_ready: ready high for %0d cycles, expected 0", ready_seen);
    end
    // Annul in DivFree blocks the start until it drops.
    start_op(32'd9, 32'd3, 1'b0);
    bus.annul_i = 1'b1;
    tick;
    tick;
    tick;
    bus.annul_i = 1'b0;
    wait_ready(edges);
    vectors++;
    if (edges !== 33 || bus.result_o !== 64'h00000000_00000003) begin
      miscompares++;
      $display("FAIL annul_restart: edges=%0d result=%h, expected edges=33 result=0000000000000003",
               edges, bus.result_o);
    end
    end_op;
  endtask

  task automatic test_reset_mid;
    int edges;
    start_op(32'd1000, 32'd10, 1'b0);
    repeat (21) tick;
    rst = 1'b0;
    #1;
    vectors++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
      miscompares++;
      $display("FAIL reset_mid_op: ready=%b result=%h, expected ready=0 result=0", bus.ready_o, bus.result_o);
    end
    bus.start_i = 1'b0;
    tick;
    rst = 1'b1;
    repeat (40) tick;
    vectors++;
    if (bus.ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_no_stale_ready: ready=%b, expected 0", bus.ready_o);
    end
    start_op(32'd1000, 32'd10, 1'b0);
    wait_ready(edges);
    vectors++;
    if (bus.result_o !== 64'h00000000_00000064) begin
      miscompares++;
      $display("FAIL pre_reset_result: got %h, expected 0000000000000064", bus.result_o);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
      miscompares++;
      $display("FAIL reset_in_end: ready=%b result=%h, expected ready=0 result=0", bus.ready_o, bus.result_o);
    end
    bus.start_i = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    start_op(32'hFFFFFFFF, 32'd1, 1'b0);
    wait_ready(edges);
    vectors++;
    if (edges !== 33 || bus.result_o !== 64'h00000000_FFFFFFFF) begin
      miscompares++;
      $display("FAIL after_reset_op: edges=%0d result=%h, expected edges=33 result=00000000ffffffff",
               edges, bus.result_o);
    end
    end_op;
  endtask

  task automatic test_back_to_back;
    int edges;
    start_op(32'hDEADBEEF, 32'h00000010, 1'b0);
    tick;
    bus.opdata1_i = 32'hFFFFFFFF;
    bus.opdata2_i = 32'd1;
    wait_ready(edges);
    // The start edge was consumed above, so ready arrives 32 edges later here.
    vectors++;
    if (edges !== 32 || bus.result_o !== 64'h0000000F_0DEADBEE) begin
      miscompares++;
      $display("FAIL operands_ignored: edges=%0d result=%h, expected edges=32 result=0000000f0deadbee",
               edges, bus.result_o);
    end
    end_op;
    start_op(32'd100, 32'd7, 1'b0);
    wait_ready(edges);
    vectors++;
    if (edges !== 33 || bus.result_o !== 64'h00000002_0000000E) begin
      miscompares++;
      $display("FAIL back_to_back: edges=%0d result=%h, expected edges=33 result=000000020000000e",
               edges, bus.result_o);
    end
    end_op;
  endtask

  initial begin
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'h0;
    bus.opdata2_i    = 32'h0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    test_reset;
    test_unsigned;
    test_signed;
    test_div_by_zero;
    test_annul;
    test_reset_mid;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
